// File: rtl/pc_if.sv
// Fetch-side control and status bundle between the pipeline front end and the PC unit.
interface pc_if #(
  parameter int WIDTH = 32
);
  logic             pc_write;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             trap;
  logic             eret;
  logic             call;
  logic             ret_pred;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] epc;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output pc_write, redirect_valid, redirect_target, trap, eret, call, ret_pred,
    input  pc, epc, ras_empty, ras_full
  );

  modport slave (
    input  pc_write, redirect_valid, redirect_target, trap, eret, call, ret_pred,
    output pc, epc, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter: next-PC selection (trap, eret, redirect, RAS, step),
// EPC capture and a circular return-address stack.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input logic  clk,
  input logic  rst,
  pc_if.slave  bus
);
  localparam int               PW     = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] W_STEP = WIDTH'(STEP);
  localparam logic [PW:0]      W_FULL = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_top;
  logic [PW:0]      r_cnt;

  logic             w_flush;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_redir_pc;
  logic [PW-1:0]    w_top_inc;
  logic [PW-1:0]    w_wr_idx;

  assign w_flush    = bus.trap | bus.eret | bus.redirect_valid;
  assign w_pc_inc   = r_pc + W_STEP;
  assign w_redir_pc = bus.redirect_target & ~(W_STEP - WIDTH'(1));
  assign w_push     = ~w_flush & bus.pc_write & bus.call;
  assign w_pop      = ~w_flush & bus.pc_write & bus.ret_pred & (r_cnt != '0);
  assign w_top_inc  = r_top + PW'(1);
  // Simultaneous call+return replaces the top in place instead of moving it.
  assign w_wr_idx   = w_pop ? r_top : w_top_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= RESET_VEC;
      r_epc <= '0;
      r_top <= '0;
      r_cnt <= '0;
    end else begin
      if (bus.trap) begin
        r_pc  <= TRAP_VEC;
        r_epc <= r_pc;
      end else if (bus.eret)
        r_pc <= r_epc;
      else if (bus.redirect_valid)
        r_pc <= w_redir_pc;
      else if (w_pop)
        r_pc <= r_ras[r_top];
      else if (bus.pc_write)
        r_pc <= w_pc_inc;

      if (w_push && !w_pop) begin
        r_top <= w_top_inc;
        if (r_cnt != W_FULL)
          r_cnt <= r_cnt + (PW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_top <= r_top - PW'(1);
        r_cnt <= r_cnt - (PW+1)'(1);
      end
    end
  end

  // Entry storage needs no reset; only count/top define validity.
  always_ff @(posedge clk) begin
    if (w_push)
      r_ras[w_wr_idx] <= w_pc_inc;
  end

  assign bus.pc        = r_pc;
  assign bus.epc       = r_epc;
  assign bus.ras_empty = (r_cnt == '0);
  assign bus.ras_full  = (r_cnt == W_FULL);
endmodule

// File: tb/tb_pc_unit.sv
// Vector-table bench for pc_unit with an expected-result queue.
module tb_pc_unit;
  typedef struct {
    logic        pw, rv, tr, er, ca, rp;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_epc;
    logic        e_emp, e_full;
  } vec_t;

  logic clk, rst;
  pc_if #(.WIDTH(32)) bus();

  pc_unit #(.WIDTH(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .STEP(4), .RAS_DEPTH(4))
    u_dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t v(logic pw, logic rv, logic [31:0] tgt, logic tr, logic er,
                             logic ca, logic rp, logic [31:0] pc, logic [31:0] epc,
                             logic emp, logic full);
    vec_t r;
    r.pw = pw; r.rv = rv; r.tgt = tgt; r.tr = tr; r.er = er; r.ca = ca; r.rp = rp;
    r.e_pc = pc; r.e_epc = epc; r.e_emp = emp; r.e_full = full;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    bus.pc_write = x.pw; bus.redirect_valid = x.rv; bus.redirect_target = x.tgt;
    bus.trap = x.tr; bus.eret = x.er; bus.call = x.ca; bus.ret_pred = x.rp;
    exp_q.push_back(x);
  endtask

  task automatic compare_out(input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", idx);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("pc[%0d]", idx), bus.pc, e.e_pc);
    chk($sformatf("epc[%0d]", idx), bus.epc, e.e_epc);
    chk($sformatf("empty[%0d]", idx), 32'(bus.ras_empty), 32'(e.e_emp));
    chk($sformatf("full[%0d]", idx), 32'(bus.ras_full), 32'(e.e_full));
  endtask

  initial begin
    //            pw rv tgt           tr er ca rp  pc            epc     emp full
    tbl.push_back(v(1,0,32'h0,        0,0,0,0, 32'h4,        32'h0,  1,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,0, 32'h8,        32'h0,  1,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,0, 32'hC,        32'h0,  1,0));
    tbl.push_back(v(0,0,32'h0,        0,0,0,0, 32'hC,        32'h0,  1,0));
    tbl.push_back(v(0,0,32'h0,        0,0,0,0, 32'hC,        32'h0,  1,0));
    tbl.push_back(v(0,1,32'h20,       0,0,0,0, 32'h20,       32'h0,  1,0));
    tbl.push_back(v(0,1,32'h1003,     0,0,0,0, 32'h1000,     32'h0,  1,0));
    tbl.push_back(v(0,1,32'h40,       0,0,0,0, 32'h40,       32'h0,  1,0));
    tbl.push_back(v(1,0,32'h0,        1,1,0,0, 32'h100,      32'h40, 1,0));
    tbl.push_back(v(0,0,32'h0,        0,1,0,0, 32'h40,       32'h40, 1,0));
    tbl.push_back(v(0,1,32'h10,       0,0,0,0, 32'h10,       32'h40, 1,0));
    tbl.push_back(v(1,0,32'h0,        0,0,1,0, 32'h14,       32'h40, 0,0));
    tbl.push_back(v(1,1,32'h50,       0,0,1,0, 32'h50,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,1,0, 32'h54,       32'h40, 0,0));
    tbl.push_back(v(0,1,32'h90,       0,0,0,0, 32'h90,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,1,0, 32'h94,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,1, 32'h94,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,1, 32'h54,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,1, 32'h14,       32'h40, 1,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,1, 32'h18,       32'h40, 1,0));
    tbl.push_back(v(0,0,32'h0,        0,0,0,1, 32'h18,       32'h40, 1,0));
    tbl.push_back(v(1,0,32'h0,        0,0,1,0, 32'h1C,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,1,0, 32'h20,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,1,0, 32'h24,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,1,0, 32'h28,       32'h40, 0,1));
    tbl.push_back(v(1,0,32'h0,        0,0,1,0, 32'h2C,       32'h40, 0,1));
    tbl.push_back(v(0,0,32'h0,        0,0,1,0, 32'h2C,       32'h40, 0,1));
    tbl.push_back(v(1,0,32'h0,        0,0,0,1, 32'h2C,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,1, 32'h28,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,1, 32'h24,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,1, 32'h20,       32'h40, 1,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,1, 32'h24,       32'h40, 1,0));
    tbl.push_back(v(1,0,32'h0,        0,0,1,0, 32'h28,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,1,1, 32'h28,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,1, 32'h2C,       32'h40, 1,0));
    tbl.push_back(v(1,0,32'h0,        0,0,1,1, 32'h30,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,1, 32'h30,       32'h40, 1,0));
    tbl.push_back(v(1,0,32'h0,        0,0,1,0, 32'h34,       32'h40, 0,0));
    tbl.push_back(v(1,0,32'h0,        1,0,0,1, 32'h100,      32'h34, 0,0));
    tbl.push_back(v(0,0,32'h0,        0,1,0,0, 32'h34,       32'h34, 0,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,1, 32'h34,       32'h34, 1,0));
    tbl.push_back(v(0,1,32'hFFFFFFFE, 0,0,0,0, 32'hFFFFFFFC, 32'h34, 1,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,0, 32'h0,        32'h34, 1,0));
    tbl.push_back(v(1,0,32'h0,        0,0,0,0, 32'h4,        32'h34, 1,0));
    tbl.push_back(v(1,0,32'h0,        0,0,1,0, 32'h8,        32'h34, 0,0));

    rst = 1'b1;
    drive(v(0,0,32'h0,0,0,0,0, 0,0,0,0));
    void'(exp_q.pop_front());
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_epc", bus.epc, 32'h0);
    chk("reset_empty", 32'(bus.ras_empty), 32'd1);
    chk("reset_full", 32'(bus.ras_full), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      @(posedge clk);
      #1;
      compare_out(i);
    end

    // Asynchronous reset mid-cycle: outputs must drop before any clock edge.
    @(negedge clk);
    drive(v(1,0,32'h0,0,0,0,0, 32'h0,32'h0,1,0));
    #2;
    rst = 1'b1;
    #1;
    compare_out(1000);
    @(posedge clk);
    #1;
    chk("rst_hold_pc", bus.pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(v(1,0,32'h0,0,0,0,0, 32'h4,32'h0,1,0));
    @(posedge clk);
    #1;
    compare_out(1001);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit, the successor to the single-register PC. It holds the fetch PC and selects the next PC from several sources: sequential step, execute-stage redirect, trap vector, exception return and a return-address-stack (RAS) prediction. It captures EPC on a trap. It sits at the head of the fetch stage. Its pc output drives instruction memory and the IF/ID pipeline register.

Parameters:
WIDTH, 32, PC and address width in bits.
RESET_VEC, 32'h0000_0000, PC value loaded on reset.
TRAP_VEC, 32'h0000_0100, PC value loaded on trap.
STEP, 4, sequential increment in bytes; power of two, 1 or greater.
RAS_DEPTH, 4, number of return-address stack entries; power of two, 2 or greater.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
pc_write  in  1  1 = fetch advances; 0 = stall (hold PC).
redirect_valid  in  1  branch/jump resolved taken in EX; load redirect_target.
redirect_target  in  WIDTH  redirect destination.
trap  in  1  exception/interrupt taken.
eret  in  1  return from exception.
call  in  1  instruction at pc is a call; push pc+STEP.
ret_pred  in  1  instruction at pc is a return; pop and predict.
pc  out  WIDTH  current fetch PC.
epc  out  WIDTH  PC saved at the last trap.
ras_empty  out  1  RAS holds no entries.
ras_full  out  1  RAS holds RAS_DEPTH entries.

Behaviour:
- Reset (async, immediate on rst high): pc = RESET_VEC, epc = 0, RAS count = 0, top pointer = 0, ras_empty = 1, ras_full = 0. RAS entry contents are don't-care.
- One-cycle latency: the selected next PC appears on pc after the next posedge. There is no combinational path from inputs to pc or epc.
- Next-PC priority, highest first:
  1. trap: pc <= TRAP_VEC, epc <= pc (current value).
  2. eret: pc <= epc.
  3. redirect_valid: pc <= redirect_target with the low log2(STEP) bits forced to 0.
  4. ret_pred with pc_write=1 and RAS non-empty: pc <= RAS top.
  5. pc_write=1: pc <= pc + STEP, modulo 2^WIDTH (wraps from max to 0, no flag).
  6. Otherwise pc holds.
- trap, eret and redirect_valid act regardless of pc_write, because a flush overrides a stall. ret_pred and call are ignored when pc_write=0.
- trap and eret in the same cycle: trap wins, and epc is updated from the current pc.
- epc changes only on trap.
- RAS is a circular buffer with a top pointer and a count in the range 0..RAS_DEPTH.
  - Push (call, pc_write=1, no higher-priority event): write pc+STEP at top+1, advance top, count increments saturating at RAS_DEPTH. When full, the push overwrites the oldest entry.
  - Pop (ret_pred accepted, count > 0): top decrements, count decrements.
  - Pop when empty: no state change; pc takes the sequential path.
  - call and ret_pred together while non-empty: the predicted pc is the old top; the top entry is replaced by pc+STEP; count is unchanged.
  - call and ret_pred together while empty: plain push; pc takes the sequential path.
  - trap, eret or redirect_valid in the same cycle suppresses RAS push and pop. The RAS is not flushed.
- ras_empty = (count==0) and ras_full = (count==RAS_DEPTH), both registered-state derived.
- Reset asserted mid-operation aborts any pending update. State returns to the reset values, and the first post-reset posedge with pc_write=1 gives pc = RESET_VEC+STEP.

Test Plan:
- Reset, then pc_write=1 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; pc_write=0 for 2 cycles -> pc holds 0xC.
- pc=0x20, pc_write=0, redirect_valid=1 with target 0x1003 -> next pc = 0x1000 (stall overridden, low bits cleared).
- pc=0x40, trap=1 and eret=1 together -> pc = 0x100, epc = 0x40; then eret=1 -> pc = 0x40, epc unchanged.
- Calls at pc 0x10, 0x50, 0x90 -> RAS holds 0x14, 0x54, 0x94; three ret_pred -> pc 0x94, 0x54, 0x14, ras_empty=1; a fourth ret_pred -> pc = prior pc + 4.
- RAS_DEPTH=4, five calls -> ras_full=1 and the oldest entry is lost; four pops return the last four pushed addresses in reverse order; the fifth pop is sequential.
- WIDTH=32 with pc=0xFFFF_FFFC and pc_write=1 -> pc = 0x0; rst pulsed asynchronously mid-cycle -> pc = 0x0 and ras_empty=1 immediately, before the next clock edge.
